// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: datapath width, opcodes, control encodings, D/E register layout.
// Pure declarations plus the immediate-extend helper; no state, no latency.
// No flow control here; consumers handle bubbles through FlushE.
package riscv_pkg;

    localparam int XLEN = 32;

    // Major opcodes accepted by the decoder
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    // ALUControl encodings
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ResultSrc encodings
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // ALUOp from the main decoder
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    // Control bundle carried into Execute; all-zero is a bubble
    typedef struct packed {
        logic             reg_write;
        logic [1:0]       result_src;
        logic             mem_write;
        logic             jump;
        logic             branch;
        logic [2:0]       alu_control;
        logic             alu_src;
        logic             illegal;
    } ctrl_t;

    // Full D/E pipeline register contents
    typedef struct packed {
        ctrl_t            ctrl;
        logic [XLEN-1:0]  rd1;
        logic [XLEN-1:0]  rd2;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  pc4;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
    } de_t;

    // Immediate extension; always sign-extends from instruction bit 31
    function automatic logic [XLEN-1:0] imm_ext(input logic [31:7] ins, input imm_src_e src);
        logic [XLEN-1:0] r;
        case (src)
            IMM_I:   r = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   r = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   r = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            default: r = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/decode_cycle_reg_file.sv
// Register file: 2 async read ports, 1 sync write port, x0 hardwired to zero; optional RF_BYPASS_EN.
// Reads are combinational; writes land on the rising edge; synchronous reset clears all registers.
// No backpressure; with RF_BYPASS_EN a same-cycle write is forwarded to matching read ports.
module reg_file
    import riscv_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      a1_i,
    input  logic [4:0]      a2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    input  logic            we_i,
    input  logic [4:0]      wa_i,
    input  logic [XLEN-1:0] wd_i
);

    logic [XLEN-1:0] regs_q [NREGS];

    // Write port: reset clears everything, writes to x0 are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // Read ports: x0 returns zero; optional forwarding of the in-flight writeback
    always_comb begin
        rd1_o = (a1_i == 5'd0) ? '0 : regs_q[a1_i];
        rd2_o = (a2_i == 5'd0) ? '0 : regs_q[a2_i];
`ifdef RF_BYPASS_EN
        if (we_i && (wa_i != 5'd0) && (wa_i == a1_i)) rd1_o = wd_i;
        if (we_i && (wa_i != 5'd0) && (wa_i == a2_i)) rd2_o = wd_i;
`endif
    end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, register read, immediate extend, D/E pipeline register.
// Latency 1 cycle (InstrD at edge N shows on *E after edge N); build option RF_BYPASS_EN.
// No stall input; FlushE turns the next D/E load into a bubble, rst has priority over FlushE.
module decode_cycle
    import riscv_pkg::*;
#(
    parameter int              NREGS  = 32,
    parameter logic [XLEN-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            FlushE,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    output logic            RegWriteE,
    output logic [1:0]      ResultSrcE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic [2:0]      ALUControlE,
    output logic            ALUSrcE,
    output logic            IllegalE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rd1, rd2;

    ctrl_t           main_ctrl;
    imm_src_e        imm_src;
    logic [1:0]      alu_op;
    logic            op_legal;
    logic [2:0]      alu_ctl;
    logic            alu_legal;

    de_t             de_d, de_q;

    assign opcode = InstrD[6:0];
    assign rd     = InstrD[11:7];
    assign funct3 = InstrD[14:12];
    assign rs1    = InstrD[19:15];
    assign rs2    = InstrD[24:20];
    assign funct7 = InstrD[31:25];

    reg_file #(.NREGS(NREGS)) u_rf (
        .clk   (clk),
        .rst   (rst),
        .a1_i  (rs1),
        .a2_i  (rs2),
        .rd1_o (rd1),
        .rd2_o (rd2),
        .we_i  (RegWriteW),
        .wa_i  (RdW),
        .wd_i  (ResultW)
    );

    // Main decoder: opcode -> control bundle, immediate format, ALUOp, opcode/funct legality
    always_comb begin
        main_ctrl = '0;
        imm_src   = IMM_I;
        alu_op    = ALUOP_ADD;
        op_legal  = 1'b1;
        case (opcode)
            OP_LW: begin
                op_legal             = (funct3 == 3'b010);
                main_ctrl.reg_write  = 1'b1;
                main_ctrl.result_src = RES_MEM;
                main_ctrl.alu_src    = 1'b1;
            end
            OP_SW: begin
                op_legal             = (funct3 == 3'b010);
                main_ctrl.mem_write  = 1'b1;
                main_ctrl.alu_src    = 1'b1;
                imm_src              = IMM_S;
            end
            OP_R: begin
                // Only funct7 0000000, or 0100000 with funct3 000 (sub), are implemented
                op_legal             = (funct7 == 7'b0000000) ||
                                       ((funct7 == 7'b0100000) && (funct3 == 3'b000));
                main_ctrl.reg_write  = 1'b1;
                alu_op               = ALUOP_FUNC;
            end
            OP_I: begin
                main_ctrl.reg_write  = 1'b1;
                main_ctrl.alu_src    = 1'b1;
                alu_op               = ALUOP_FUNC;
            end
            OP_BEQ: begin
                op_legal             = (funct3 == 3'b000);
                main_ctrl.branch     = 1'b1;
                imm_src              = IMM_B;
                alu_op               = ALUOP_SUB;
            end
            OP_JAL: begin
                main_ctrl.reg_write  = 1'b1;
                main_ctrl.jump       = 1'b1;
                main_ctrl.result_src = RES_PC4;
                imm_src              = IMM_J;
            end
            default: op_legal = 1'b0;
        endcase
    end

    // ALU decoder: ALUOp plus funct3/funct7[5]; addi never becomes sub
    always_comb begin
        alu_ctl   = ALU_ADD;
        alu_legal = 1'b1;
        case (alu_op)
            ALUOP_ADD: alu_ctl = ALU_ADD;
            ALUOP_SUB: alu_ctl = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000:  alu_ctl = ((opcode == OP_R) && funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_ctl = ALU_SLT;
                    3'b110:  alu_ctl = ALU_OR;
                    3'b111:  alu_ctl = ALU_AND;
                    default: alu_legal = 1'b0;
                endcase
            end
        endcase
    end

    // D/E next state: decoded fields, bubble on illegal control, all-zero on FlushE
    always_comb begin
        de_d                  = '0;
        de_d.ctrl             = main_ctrl;
        de_d.ctrl.alu_control = alu_ctl;
        if (!(op_legal && alu_legal)) begin
            de_d.ctrl         = '0;
            de_d.ctrl.illegal = 1'b1;
        end
        de_d.rd1 = rd1;
        de_d.rd2 = rd2;
        de_d.imm = imm_ext(InstrD[31:7], imm_src);
        de_d.pc  = PCD;
        de_d.pc4 = PCPlus4D;
        de_d.rs1 = rs1;
        de_d.rs2 = rs2;
        de_d.rd  = rd;
        if (FlushE) begin
            de_d = '0;
        end
    end

    // D/E register: reset loads the reset PC pair, otherwise takes the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            de_q     <= '0;
            de_q.pc  <= RST_PC;
            de_q.pc4 <= RST_PC + 32'd4;
        end else begin
            de_q     <= de_d;
        end
    end

    assign RegWriteE   = de_q.ctrl.reg_write;
    assign ResultSrcE  = de_q.ctrl.result_src;
    assign MemWriteE   = de_q.ctrl.mem_write;
    assign JumpE       = de_q.ctrl.jump;
    assign BranchE     = de_q.ctrl.branch;
    assign ALUControlE = de_q.ctrl.alu_control;
    assign ALUSrcE     = de_q.ctrl.alu_src;
    assign IllegalE    = de_q.ctrl.illegal;
    assign RD1E        = de_q.rd1;
    assign RD2E        = de_q.rd2;
    assign ImmExtE     = de_q.imm;
    assign Rs1E        = de_q.rs1;
    assign Rs2E        = de_q.rs2;
    assign RdE         = de_q.rd;
    assign PCE         = de_q.pc;
    assign PCPlus4E    = de_q.pc4;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed + randomized bench for decode_cycle against a behavioural RV32I decode model.
// Outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Model register array is updated after each edge, reads use pre-edge contents.
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        FlushE, RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;

    int n_pass = 0;
    int n_chk  = 0;

    logic [31:0] mregs [32];

    typedef struct packed {
        logic        ill;
        logic        regw;
        logic [1:0]  rsrc;
        logic        memw;
        logic        jump;
        logic        branch;
        logic [2:0]  alu;
        logic        alusrc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        chk_imm;
    } exp_t;

    decode_cycle dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
        .IllegalE(IllegalE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCE(PCE), .PCPlus4E(PCPlus4E)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    endtask

    // Register read as the architecture sees it from Decode
    function automatic logic [31:0] rf_read(input logic [4:0] a, input logic w,
                                            input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
        if (w && wa != 5'd0 && wa == a) return wd;
`endif
        return mregs[a];
    endfunction

    // Reference decode written from the instruction-set rules
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] pc4, input logic w,
                                   input logic [4:0] wa, input logic [31:0] wd);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int sx;
        bit legal;
        e = '0;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        sx = $signed(ins);
        legal = 1'b0;
        if (op == 7'h03 && f3 == 3'd2) begin
            legal = 1; e.regw = 1; e.rsrc = 2'd1; e.alusrc = 1; e.imm = 32'(sx >>> 20);
        end else if (op == 7'h23 && f3 == 3'd2) begin
            legal = 1; e.memw = 1; e.alusrc = 1;
            e.imm = 32'((sx >>> 25) * 32) + 32'(ins[11:7]);
        end else if (op == 7'h33 || op == 7'h13) begin
            e.regw = 1;
            e.alusrc = (op == 7'h13);
            legal = (f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7);
            if (op == 7'h33) legal = legal && (f7 == 7'd0 || (f7 == 7'h20 && f3 == 3'd0));
            case (f3)
                3'd0:    e.alu = (op == 7'h33 && f7 == 7'h20) ? 3'd1 : 3'd0;
                3'd2:    e.alu = 3'd5;
                3'd6:    e.alu = 3'd3;
                default: e.alu = 3'd2;
            endcase
            e.imm = 32'(sx >>> 20);
        end else if (op == 7'h63 && f3 == 3'd0) begin
            legal = 1; e.branch = 1; e.alu = 3'd1;
            e.imm = 32'((sx >>> 31) * 4096) + 32'(ins[7]) * 2048 + 32'(ins[30:25]) * 32
                  + 32'(ins[11:8]) * 2;
        end else if (op == 7'h6F) begin
            legal = 1; e.regw = 1; e.jump = 1; e.rsrc = 2'd2;
            e.imm = 32'((sx >>> 31) * 1048576) + 32'(ins[19:12]) * 4096
                  + 32'(ins[20]) * 2048 + 32'(ins[30:21]) * 2;
        end
        if (!legal) begin
            e.regw = 0; e.rsrc = 0; e.memw = 0; e.jump = 0; e.branch = 0;
            e.alu = 0; e.alusrc = 0;
        end
        e.ill     = !legal;
        e.chk_imm = legal;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd  = ins[11:7];
        e.rd1 = rf_read(e.rs1, w, wa, wd);
        e.rd2 = rf_read(e.rs2, w, wa, wd);
        e.pc  = pc;
        e.pc4 = pc4;
        return e;
    endfunction

    // One edge: drive, predict, clock, compare every output
    task automatic step(input logic [31:0] ins, input logic fl, input logic w,
                        input logic [4:0] wa, input logic [31:0] wd, input logic r,
                        input logic [31:0] pc, output exp_t e);
        InstrD = ins; PCD = pc; PCPlus4D = pc + 32'd4;
        FlushE = fl; RegWriteW = w; RdW = wa; ResultW = wd; rst = r;
        e = model(ins, pc, pc + 32'd4, w, wa, wd);
        if (r || fl) begin
            e = '0;
            e.chk_imm = 1;
            if (r) e.pc4 = 32'd4;
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        end else if (w && wa != 5'd0) begin
            mregs[wa] = wd;
        end
        #1;
        chk("RegWriteE",   {31'd0, RegWriteE}, {31'd0, e.regw});
        chk("ResultSrcE",  {30'd0, ResultSrcE}, {30'd0, e.rsrc});
        chk("MemWriteE",   {31'd0, MemWriteE}, {31'd0, e.memw});
        chk("JumpE",       {31'd0, JumpE}, {31'd0, e.jump});
        chk("BranchE",     {31'd0, BranchE}, {31'd0, e.branch});
        chk("ALUControlE", {29'd0, ALUControlE}, {29'd0, e.alu});
        chk("ALUSrcE",     {31'd0, ALUSrcE}, {31'd0, e.alusrc});
        chk("IllegalE",    {31'd0, IllegalE}, {31'd0, e.ill});
        chk("RD1E", RD1E, e.rd1);
        chk("RD2E", RD2E, e.rd2);
        if (e.chk_imm) chk("ImmExtE", ImmExtE, e.imm);
        chk("Rs1E", {27'd0, Rs1E}, {27'd0, e.rs1});
        chk("Rs2E", {27'd0, Rs2E}, {27'd0, e.rs2});
        chk("RdE",  {27'd0, RdE}, {27'd0, e.rd});
        chk("PCE", PCE, e.pc);
        chk("PCPlus4E", PCPlus4E, e.pc4);
    endtask

    initial begin
        exp_t e;
        logic [31:0] ins;
        logic [6:0]  ops [6];
        ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33;
        ops[3] = 7'h13; ops[4] = 7'h63; ops[5] = 7'h6F;
        for (int i = 0; i < 32; i++) mregs[i] = 32'hDEAD_BEEF;

        // Reset held for two edges
        step(32'h0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 32'h0, e);
        step(32'h0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 32'h0, e);
        chk("rst_PCPlus4E_const", PCPlus4E, 32'd4);

        // Registers read zero after reset
        step(32'h00528313, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'h100, e);
        chk("rst_read_x5", RD1E, 32'd0);

        // Write x5 = 0x10, then addi x6,x5,5
        step(32'h00000013, 1'b0, 1'b1, 5'd5, 32'h10, 1'b0, 32'h104, e);
        step(32'h00528313, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'h108, e);
        chk("addi_RD1E_const", RD1E, 32'h10);
        chk("addi_Imm_const", ImmExtE, 32'd5);

        // sub x4,x5,x6
        step(32'h40628233, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'h10C, e);
        chk("sub_ALU_const", {29'd0, ALUControlE}, 32'd1);

        // beq x0,x0,-4 then the same instruction with FlushE
        step(32'hFE000EE3, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'h110, e);
        chk("beq_Imm_const", ImmExtE, 32'hFFFF_FFFC);
        step(32'hFE000EE3, 1'b1, 1'b1, 5'd7, 32'h77, 1'b0, 32'h114, e);

        // Same-cycle write of x5 while Decode reads it
        step(32'h00528313, 1'b0, 1'b1, 5'd5, 32'hAA, 1'b0, 32'h118, e);
`ifdef RF_BYPASS_EN
        chk("bypass_RD1E_const", RD1E, 32'hAA);
`else
        chk("nobypass_RD1E_const", RD1E, 32'h10);
`endif
        // Write to x0 is dropped; x7 written under flush is visible
        step(32'h00700013, 1'b0, 1'b1, 5'd0, 32'h55, 1'b0, 32'h11C, e);
        step(32'h00038013, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'h120, e);
        chk("flush_write_x7", RD1E, 32'h77);
        step(32'h00000033, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'h124, e);
        chk("x0_RD1E_const", RD1E, 32'd0);

        // Illegal instruction
        step(32'hFFFFFFFF, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'h128, e);
        chk("illegal_const", {31'd0, IllegalE}, 32'd1);

        // Randomized traffic: mostly legal opcodes, random funct/flush/write/reset
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 9) != 0) ins[6:0] = ops[$urandom_range(0, 5)];
            if (ins[6:0] == 7'h33 && $urandom_range(0, 3) != 0)
                ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            if ((ins[6:0] == 7'h03 || ins[6:0] == 7'h23) && $urandom_range(0, 3) != 0)
                ins[14:12] = 3'd2;
            if (ins[6:0] == 7'h63 && $urandom_range(0, 3) != 0) ins[14:12] = 3'd0;
            step(ins, ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), $urandom, ($urandom_range(0, 49) == 0),
                 $urandom & 32'hFFFF_FFFC, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
